// File: rtl/spi_pkg.sv
// Shared state encoding and sizing helpers for the SPI master arbiter.
package spi_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      END
   } state_t;

   // Ceiling log2, never less than 1 so it can size a counter or pointer.
   function automatic int clog2(input int n);
      int w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick import spi_pkg::*; #(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          any_req
);

   logic [PW:0] idx;
   logic        found;

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         idx = {1'b0, ptr} + (PW+1)'(off);
         if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
         if (!found && req[idx[PW-1:0]]) begin
            grant[idx[PW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters,
// holding the grant and that requester's chip-select for a whole burst.
module spi_master_arbiter import spi_pkg::*; #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int BUSY_TIMEOUT = 16,
   parameter int CS_GAP       = 2
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [NUM_REQ-1:0]            ReqValid,
   input  logic [NUM_REQ-1:0]            ReqLast,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
   output logic [NUM_REQ-1:0]            ReqReady,
   output logic [NUM_REQ-1:0]            RspValid,
   output logic [DATA_WIDTH-1:0]         RspData,
   output logic [NUM_REQ-1:0]            Grant,
   output logic [NUM_REQ-1:0]            CS_n,
   output logic                          Error,
   output logic                          MStart,
   output logic [DATA_WIDTH-1:0]         MTxData,
   input  logic                          MDone,
   input  logic [DATA_WIDTH-1:0]         MRxData
);

   localparam int PW = clog2(NUM_REQ);
   localparam int TW = clog2(BUSY_TIMEOUT);
   localparam int GW = clog2(CS_GAP + 1);

   state_t                state;
   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         g_idx;
   logic [PW-1:0]         pick_idx;
   logic [NUM_REQ-1:0]    pick;
   logic                  any_req;
   logic [TW-1:0]         to_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  last_r;
   logic                  mdone_q;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req     (ReqValid),
      .ptr     (rr_ptr),
      .grant   (pick),
      .any_req (any_req)
   );

   always_comb begin
      pick_idx = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i])  pick_idx = PW'(i);
         if (Grant[i]) sel_data = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign sel_valid = |(ReqValid & Grant);
   assign sel_last  = |(ReqLast & Grant);

   // NOTE: all registered state uses non-blocking assignments so each flop sees pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         Grant    <= '0;
         CS_n     <= '1;
         ReqReady <= '0;
         RspValid <= '0;
         RspData  <= '0;
         Error    <= 1'b0;
         MStart   <= 1'b0;
         MTxData  <= '0;
         rr_ptr   <= '0;
         g_idx    <= '0;
         to_cnt   <= '0;
         gap_cnt  <= '0;
         last_r   <= 1'b0;
         mdone_q  <= 1'b1;
      end else begin
         ReqReady <= '0;
         RspValid <= '0;
         Error    <= 1'b0;
         MStart   <= 1'b0;
         mdone_q  <= MDone;
         case (state)
            IDLE: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (MDone && any_req) begin
                  Grant <= pick;
                  g_idx <= pick_idx;
                  state <= SELECT;
               end
            end
            SELECT: begin
               CS_n  <= ~Grant;
               state <= LAUNCH;
            end
            LAUNCH: begin
               // The grant is kept while the owner stalls; other requesters wait.
               if (sel_valid) begin
                  MTxData  <= sel_data;
                  last_r   <= sel_last;
                  ReqReady <= Grant;
                  MStart   <= 1'b1;
                  to_cnt   <= '0;
                  state    <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!MDone) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                  Error <= 1'b1;
                  state <= END;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!mdone_q && MDone) begin
                  RspData  <= MRxData;
                  RspValid <= Grant;
                  state    <= last_r ? END : LAUNCH;
               end
            end
            END: begin
               CS_n    <= '1;
               Grant   <= '0;
               rr_ptr  <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
               gap_cnt <= GW'(CS_GAP);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
